// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative unsigned
// MUL (shift-add) and DIV (restoring), behind a valid/ready handshake.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] hi,
    output logic             cf,
    output logic             of,
    output logic             sf,
    output logic             pf,
    output logic             zf,
    output logic             err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_NOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;

    localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    logic [1:0]       state_q, state_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] wh_q, wh_d, wl_q, wl_d, opb_q, opb_d;
    logic [WIDTH-1:0] f_q, f_d, hi_q, hi_d;
    logic             cf_q, cf_d, of_q, of_d, sf_q, sf_d;
    logic             pf_q, pf_d, zf_q, zf_d, err_q, err_d;

    // {sign, zero, even parity} of a result word
    function automatic logic [2:0] szp(input logic [WIDTH-1:0] v);
        return {v[WIDTH-1], ~|v, ~^v};
    endfunction

    logic signed [WIDTH-1:0] a_s, b_s;
    logic [SHW-1:0]          sh;
    logic [WIDTH:0]          sum, diff;
    logic [WIDTH-1:0]        sc_f;
    logic                    sc_cf, sc_of, sc_err;

    assign a_s  = a;
    assign b_s  = b;
    assign sh   = b[SHW-1:0];
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        sc_f   = '0;
        sc_cf  = 1'b0;
        sc_of  = 1'b0;
        sc_err = 1'b0;
        case (op)
            OP_AND: sc_f = a & b;
            OP_OR:  sc_f = a | b;
            OP_ADD: begin
                sc_f  = sum[WIDTH-1:0];
                sc_cf = sum[WIDTH];
                sc_of = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR: sc_f = a ^ b;
            OP_NOR: sc_f = ~(a | b);
            OP_SLL: sc_f = a << sh;
            OP_SUB: begin
                sc_f  = diff[WIDTH-1:0];
                sc_cf = diff[WIDTH];
                sc_of = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: sc_f = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SRL: sc_f = a >> sh;
            OP_SRA: sc_f = $unsigned(a_s >>> sh);
            default: sc_err = 1'b1;
        endcase
    end

    // One MUL/DIV iteration: wh holds the partial high word / remainder,
    // wl holds the multiplier bits being consumed / dividend becoming quotient.
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_trial, it_hi, it_lo;
    logic             div_ge;

    assign mul_sum   = {1'b0, wh_q} + (wl_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {wh_q, wl_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opb_q};
    assign div_trial = div_shift[WIDTH-1:0] - opb_q;

    always_comb begin
        if (is_div_q) begin
            it_hi = div_ge ? div_trial : div_shift[WIDTH-1:0];
            it_lo = {wl_q[WIDTH-2:0], div_ge};
        end else begin
            it_hi = mul_sum[WIDTH:1];
            it_lo = {mul_sum[0], wl_q[WIDTH-1:1]};
        end
    end

    logic accept;
    assign in_ready  = rst_n && ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        wh_d     = wh_q;
        wl_d     = wl_q;
        opb_d    = opb_q;
        f_d      = f_q;
        hi_d     = hi_q;
        cf_d     = cf_q;
        of_d     = of_q;
        sf_d     = sf_q;
        pf_d     = pf_q;
        zf_d     = zf_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (op == OP_MUL || op == OP_DIV) begin
                        state_d  = S_BUSY;
                        cnt_d    = CNT_LOAD;
                        is_div_d = (op == OP_DIV);
                        wh_d     = '0;
                        wl_d     = a;
                        opb_d    = b;
                    end else begin
                        state_d            = S_DONE;
                        f_d                = sc_f;
                        hi_d               = '0;
                        cf_d               = sc_cf;
                        of_d               = sc_of;
                        {sf_d, zf_d, pf_d} = szp(sc_f);
                        err_d              = sc_err;
                    end
                end else if (state_q == S_DONE && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                wh_d  = it_hi;
                wl_d  = it_lo;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d            = S_DONE;
                    f_d                = it_lo;
                    hi_d               = it_hi;
                    cf_d               = !is_div_q && (it_hi != '0);
                    of_d               = !is_div_q && (it_hi != '0);
                    {sf_d, zf_d, pf_d} = szp(it_lo);
                    err_d              = is_div_q && (opb_q == '0);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            f_q      <= '0;
            hi_q     <= '0;
            cf_q     <= 1'b0;
            of_q     <= 1'b0;
            sf_q     <= 1'b0;
            pf_q     <= 1'b0;
            zf_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            f_q      <= f_d;
            hi_q     <= hi_d;
            cf_q     <= cf_d;
            of_q     <= of_d;
            sf_q     <= sf_d;
            pf_q     <= pf_d;
            zf_q     <= zf_d;
            err_q    <= err_d;
        end
    end

    // Iteration working registers are pure data and need no reset
    always_ff @(posedge clk) begin
        wh_q  <= wh_d;
        wl_q  <= wl_d;
        opb_q <= opb_d;
    end

    assign f   = f_q;
    assign hi  = hi_q;
    assign cf  = cf_q;
    assign of  = of_q;
    assign sf  = sf_q;
    assign pf  = pf_q;
    assign zf  = zf_q;
    assign err = err_q;
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed scenarios plus randomized ops checked against an
// arithmetic reference model.
module tb_alu_mc;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] f, hi;
    logic         cf, of, sf, pf, zf, err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] f;
        logic [31:0] hi;
        logic        cf, of, sf, pf, zf, err;
    } res_t;

    res_t got;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .hi(hi), .cf(cf), .of(of), .sf(sf), .pf(pf), .zf(zf), .err(err)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        res_t        r;
        logic [63:0] p;
        longint      sr;
        int          s;
        r = '0;
        s = int'(y[4:0]);
        case (o)
            4'd0: r.f = x & y;
            4'd1: r.f = x | y;
            4'd2: begin
                p    = 64'(x) + 64'(y);
                r.f  = p[31:0];
                r.cf = (p > 64'h0000_0000_FFFF_FFFF);
                sr   = longint'(signed'(x)) + longint'(signed'(y));
                r.of = (sr != longint'(signed'(r.f)));
            end
            4'd3: r.f = x ^ y;
            4'd4: r.f = ~(x | y);
            4'd5: r.f = x << s;
            4'd6: begin
                r.f  = x - y;
                r.cf = (x < y);
                sr   = longint'(signed'(x)) - longint'(signed'(y));
                r.of = (sr != longint'(signed'(r.f)));
            end
            4'd7: r.f = (signed'(x) < signed'(y)) ? 32'd1 : 32'd0;
            4'd8: begin
                p    = 64'(x) * 64'(y);
                r.f  = p[31:0];
                r.hi = p[63:32];
                r.cf = (r.hi != 0);
                r.of = (r.hi != 0);
            end
            4'd9: begin
                if (y == 0) begin
                    r.f   = 32'hFFFF_FFFF;
                    r.hi  = x;
                    r.err = 1'b1;
                end else begin
                    r.f  = x / y;
                    r.hi = x % y;
                end
            end
            4'd10: r.f = x >> s;
            4'd11: r.f = 32'(signed'(x) >>> s);
            default: r.err = 1'b1;
        endcase
        r.sf = r.f[31];
        r.zf = (r.f == 0);
        r.pf = (($countones(r.f) % 2) == 0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input res_t e);
        chk({tag, "_f"},   f,   e.f);
        chk({tag, "_hi"},  hi,  e.hi);
        chk({tag, "_cf"},  cf,  e.cf);
        chk({tag, "_of"},  of,  e.of);
        chk({tag, "_sf"},  sf,  e.sf);
        chk({tag, "_pf"},  pf,  e.pf);
        chk({tag, "_zf"},  zf,  e.zf);
        chk({tag, "_err"}, err, e.err);
    endtask

    // Issue one op from idle (called at a falling edge), keep garbage on the
    // inputs while it runs, check latency and result, then consume it.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        res_t e;
        int   cyc;
        int   lat;
        e   = model(o, x, y);
        lat = (o == 4'd8 || o == 4'd9) ? W + 1 : 1;
        chk({tag, "_in_ready_idle"}, in_ready, 1);
        in_valid  = 1'b1;
        op        = o;
        a         = x;
        b         = y;
        out_ready = 1'b0;
        @(negedge clk);
        cyc = 1;
        op  = 4'($urandom);
        a   = $urandom;
        b   = $urandom;
        while (!out_valid && cyc < 60) begin
            chk({tag, "_in_ready_busy"}, in_ready, 0);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, cyc, lat);
        chk_res(tag, e);
        got       = {f, hi, cf, of, sf, pf, zf, err};
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        res_t        e;
        logic [3:0]  o;
        logic [31:0] x, y;
        logic        stale;

        // Reset state
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_f", f, 0);
        chk("rst_hi", hi, 0);
        chk("rst_flags", {cf, of, sf, pf, zf, err}, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_in_ready", in_ready, 1);

        // Directed cases
        run_op("add_ovf", 4'd2, 32'h7FFF_FFFF, 32'd1);
        chk("add_ovf_f_const", got.f, 32'h8000_0000);
        chk("add_ovf_of_const", got.of, 1);
        chk("add_ovf_pf_const", got.pf, 0);
        run_op("sub_borrow", 4'd6, 32'd0, 32'd1);
        chk("sub_borrow_cf_const", got.cf, 1);
        chk("sub_borrow_pf_const", got.pf, 1);
        run_op("slt_neg", 4'd7, 32'hFFFF_FFFF, 32'd1);
        chk("slt_neg_f_const", got.f, 1);
        run_op("mul_big", 4'd8, 32'hFFFF_FFFF, 32'd2);
        chk("mul_big_hi_const", got.hi, 1);
        chk("mul_big_f_const", got.f, 32'hFFFF_FFFE);
        run_op("div_100_7", 4'd9, 32'd100, 32'd7);
        chk("div_q_const", got.f, 14);
        chk("div_r_const", got.hi, 2);
        run_op("div_zero", 4'd9, 32'd5, 32'd0);
        chk("div0_err_const", got.err, 1);
        chk("div0_hi_const", got.hi, 5);
        run_op("illegal13", 4'd13, 32'h1234_5678, 32'h9ABC_DEF0);
        chk("illegal_zf_const", got.zf, 1);
        run_op("sll_31", 4'd5, 32'h0000_0003, 32'hFFFF_FFFF);
        run_op("srl_upper_b_ignored", 4'd10, 32'h8000_0000, 32'h0000_0101);

        // Backpressure on SRA, then a pending ADD accepted on the release edge
        in_valid  = 1'b1;
        op        = 4'd11;
        a         = 32'h8000_0000;
        b         = 32'd4;
        out_ready = 1'b0;
        @(negedge clk);
        op = 4'd2;
        a  = 32'd1;
        b  = 32'd2;
        e  = model(4'd11, 32'h8000_0000, 32'd4);
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_f_held", f, 32'hF800_0000);
            chk("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        chk_res("bp_sra", e);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_next_out_valid", out_valid, 1);
        chk_res("bp_add", model(4'd2, 32'd1, 32'd2));
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_drain", out_valid, 0);

        // Back-to-back single-cycle stream at full throughput
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            o = 4'($urandom_range(0, 15));
            if (o == 4'd8 || o == 4'd9) o = o + 4'd4;
            x = $urandom;
            y = $urandom;
            in_valid = 1'b1;
            op = o;
            a  = x;
            b  = y;
            @(negedge clk);
            chk("stream_out_valid", out_valid, 1);
            chk("stream_in_ready", in_ready, 1);
            chk_res("stream", model(o, x, y));
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("stream_drain", out_valid, 0);

        // Reset in the middle of a MUL
        in_valid = 1'b1;
        op = 4'd8;
        a  = 32'hDEAD_BEEF;
        b  = 32'h1234_5678;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_f", f, 0);
        chk("midrst_hi", hi, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_release_in_ready", in_ready, 1);
        stale = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("midrst_no_stale", stale, 0);

        // Randomized ops against the model
        for (int i = 0; i < 30; i++) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op("rand", o, x, y);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the 8-op combinational datapath ALU.
- Keeps the existing 4-bit op encoding and the CF/OF/SF/PF/ZF flag set, with width-correct flag semantics.
- Adds logical and arithmetic right shifts, an iterative unsigned multiply and an iterative unsigned divide.
- Wraps everything in a valid/ready handshake so the MIPS execute stage can stall on long operations.

Parameters:
- WIDTH, 32: operand and result width. Must be a power of two, 8 or greater.
- SHW, $clog2(WIDTH): shift-amount width. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept an operation this cycle.
- op  in  4  operation code.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result registers valid.
- out_ready  in  1  consumer accepts the result.
- f  out  WIDTH  result: low product, or quotient.
- hi  out  WIDTH  high product or remainder; 0 for all other ops.
- cf, of, sf, pf, zf  out  1 each  flags.
- err  out  1  illegal op, or divide by zero.

Behaviour:
- Op codes:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SLL, 6 SUB, 7 SLT (signed).
  - 8 MUL (unsigned), 9 DIV (unsigned), 10 SRL, 11 SRA.
  - 12–15 are illegal.
- Shifts use b[SHW-1:0] as the amount; upper bits of b are ignored.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept: an operation is accepted on a rising edge with in_valid && in_ready. a, b and op are captured on that edge and may change afterwards.
- Single-cycle ops (0–7, 10–12+): the result is registered at the accept edge; go to DONE. out_valid is high from the edge after acceptance (latency 1).
- MUL and DIV: go to BUSY with counter = WIDTH.
  - One iteration per cycle: shift-add for MUL, restoring subtract for DIV.
  - At counter==1, go to DONE.
  - out_valid rises exactly WIDTH+1 cycles after the accept edge; 33 for WIDTH=32.
- DONE:
  - out_valid=1 and all outputs are held stable until out_ready.
  - out_ready without a new accept: go to IDLE, out_valid=0 next cycle.
  - out_ready with in_valid (back-to-back): the new op is accepted on the same edge, giving full throughput for single-cycle ops.
- in_valid in BUSY is ignored; in_ready=0.
- Flags are registered with the result:
  - ADD: cf = carry out of bit WIDTH-1; of = signed overflow (operand signs equal, result sign differs).
  - SUB: cf = borrow (a<b unsigned); of = signed overflow (operand signs differ, result sign differs from a).
  - MUL: cf = of = (hi != 0).
  - All other ops: cf = of = 0.
  - sf = f[WIDTH-1]; zf = (f==0); pf = even parity of f (1 when the count of ones is even).
- err:
  - Illegal op: f=0, hi=0, err=1, flags computed on f=0 (zf=1, pf=1). Latency 1.
  - DIV with b==0: completes the full WIDTH+1 latency with f = all ones, hi = a, err=1.
- Reset: async assertion forces IDLE immediately, including mid-BUSY (the operation is aborted and no result is produced).
  - in_ready = 0 while rst_n=0; it is 1 in the first cycle after deassertion.
  - out_valid, f, hi, all flags, err and the counter reset to 0.

Test Plan:
- ADD a=0x7FFFFFFF b=1 -> f=0x80000000, of=1, cf=0, sf=1, zf=0, pf=0, out_valid one cycle after accept.
- SUB a=0 b=1 -> f=0xFFFFFFFF, cf=1, of=0, sf=1, pf=1. Then SLT a=0xFFFFFFFF b=1 -> f=1.
- MUL a=0xFFFFFFFF b=2 -> hi=1, f=0xFFFFFFFE, cf=of=1, out_valid exactly 33 cycles after accept, in_ready=0 throughout BUSY.
- DIV a=100 b=7 -> f=14, hi=2, err=0. DIV a=5 b=0 -> f=0xFFFFFFFF, hi=5, err=1. op=13 -> err=1, f=0, zf=1.
- Backpressure: hold out_ready=0 for 5 cycles after an SRA a=0x80000000 b=4 -> f=0xF8000000 held stable, in_ready=0; then out_ready=1 with a new ADD pending -> accepted the same edge.
- Assert rst_n=0 at cycle 10 of a MUL -> immediate out_valid=0, in_ready=0; after release, in_ready=1 and no stale result ever appears.
